// File: rtl/student_tlul_sample_fifo.sv
// TL-UL slave sample FIFO: DATA/STATUS/CTRL registers feeding a ready/valid sample stream.
// Define STUDENT_SAMPLE_FIFO_ERR_EN to flag dropped (overflowing) pushes with d_error.
package tlul_pkg;
  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module student_tlul_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  tlul_pkg::tl_h2d_t  tl_i,
  output tlul_pkg::tl_d2h_t  tl_o,
  output logic [DW-1:0]      sample_o,
  output logic               sample_valid_o,
  input  logic               sample_ready_i
);
  import tlul_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [5:0] ADDR_DATA   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h04;
  localparam logic [5:0] ADDR_CTRL   = 6'h08;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   level;
  logic          overflow;

  logic          d_valid;
  tl_d_op_e      d_opcode;
  logic [1:0]    d_size;
  logic [7:0]    d_source;
  logic [31:0]   d_data;
  logic          d_error;

  logic a_ready, accept, is_get, is_put;
  logic sel_data, sel_status, sel_ctrl;
  logic empty, full, pop, push_req, push, drop, flush;
  logic [31:0] status_word, rsp_data;
  logic        rsp_error;
  logic        unused_tl;

  assign unused_tl = ^{tl_i.a_param, tl_i.a_mask, tl_i.a_address[31:6], tl_i.a_data};

  assign a_ready    = !d_valid;
  assign accept     = tl_i.a_valid && a_ready;
  assign is_get     = (tl_i.a_opcode == Get);
  assign is_put     = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
  assign sel_data   = (tl_i.a_address[5:0] == ADDR_DATA);
  assign sel_status = (tl_i.a_address[5:0] == ADDR_STATUS);
  assign sel_ctrl   = (tl_i.a_address[5:0] == ADDR_CTRL);

  assign empty    = (level == '0);
  assign full     = (level == LVL_FULL);
  assign pop      = !empty && sample_ready_i;
  assign push_req = accept && is_put && sel_data;
  // A full FIFO still takes a push when the stream frees a slot in the same cycle.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign flush    = accept && is_put && sel_ctrl && tl_i.a_data[0];

  assign sample_valid_o = !empty;
  assign sample_o       = empty ? '0 : mem[rptr];

  always_comb begin
    status_word       = '0;
    status_word[AW:0] = level;
    status_word[16]   = empty;
    status_word[17]   = full;
    status_word[18]   = overflow;
  end

  always_comb begin
    rsp_data  = '0;
    rsp_error = 1'b0;
    if (!(is_get || is_put)) begin
      rsp_error = 1'b1;
    end else if (sel_data) begin
      if (is_get) rsp_data[DW-1:0] = sample_o;
`ifdef STUDENT_SAMPLE_FIFO_ERR_EN
      else rsp_error = drop;
`endif
    end else if (sel_status) begin
      if (is_get) rsp_data = status_word;
    end else if (!sel_ctrl) begin
      rsp_error = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_valid  <= 1'b0;
      d_opcode <= AccessAck;
      d_size   <= '0;
      d_source <= '0;
      d_data   <= '0;
      d_error  <= 1'b0;
    end else if (accept) begin
      d_valid  <= 1'b1;
      d_opcode <= is_get ? AccessAckData : AccessAck;
      d_size   <= tl_i.a_size;
      d_source <= tl_i.a_source;
      d_data   <= rsp_data;
      d_error  <= rsp_error;
    end else if (tl_i.d_ready) begin
      d_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= tl_i.a_data[DW-1:0];
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = d_valid;
    tl_o.d_opcode = d_opcode;
    tl_o.d_size   = d_size;
    tl_o.d_source = d_source;
    tl_o.d_data   = d_data;
    tl_o.d_error  = d_error;
    tl_o.a_ready  = a_ready;
  end
endmodule

// File: tb/tb_student_tlul_sample_fifo.sv
// Bench for student_tlul_sample_fifo: vector table, directed corner sequences and a
// randomized phase checked against a queue-based model of the FIFO.
module tb_student_tlul_sample_fifo;
  import tlul_pkg::*;

  localparam int DEPTH = 16;
  localparam int DW    = 16;
`ifdef STUDENT_SAMPLE_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_ni = 1'b1;
  tl_h2d_t       tl_i;
  tl_d2h_t       tl_o;
  logic [DW-1:0] sample_o;
  logic          sample_valid;
  logic          sample_ready;

  always #5 clk = ~clk;

  student_tlul_sample_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .tl_i           (tl_i),
    .tl_o           (tl_o),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid),
    .sample_ready_i (sample_ready)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q[$];
  bit          ovf = 1'b0;
  bit          rand_ready = 1'b0;

  typedef struct {
    tl_a_op_e    op;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;
  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] status_exp();
    logic [8:0] lvl;
    lvl = 9'(q.size());
    return {13'b0, ovf, (q.size() == DEPTH), (q.size() == 0), 7'b0, lvl};
  endfunction

  function automatic logic [31:0] head_exp();
    return (q.size() > 0) ? q[0] : 32'h0;
  endfunction

  // One clock: check the stream outputs, then apply this cycle's events to the model.
  task automatic tick(input bit push, input logic [31:0] pdata, input bit flush);
    bit pop;
    chk("sample_valid", 32'(sample_valid), 32'(q.size() > 0));
    chk("sample_o", 32'(sample_o), head_exp());
    pop = sample_ready && (q.size() > 0);
    @(posedge clk);
    if (flush) begin
      q.delete();
      ovf = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) q.push_back(pdata & 32'h0000_FFFF);
        else ovf = 1'b1;
      end
    end
    #1;
  endtask

  task automatic bus(input tl_a_op_e op, input logic [5:0] addr, input logic [31:0] wdata,
                     input bit sr, input int hold, output logic [31:0] rdata, output bit err);
    bit          put, pop;
    logic [31:0] exp_data;
    bit          exp_err;
    logic [7:0]  src;
    logic [1:0]  sz;
    src = 8'($urandom);
    sz  = 2'($urandom);
    put = (op != Get);
    sample_ready     = sr;
    tl_i.a_valid     = 1'b1;
    tl_i.a_opcode    = op;
    tl_i.a_param     = 3'h0;
    tl_i.a_size      = sz;
    tl_i.a_source    = src;
    tl_i.a_address   = {26'($urandom), addr};
    tl_i.a_mask      = 4'hF;
    tl_i.a_data      = wdata;
    tl_i.d_ready     = 1'b0;
    pop      = sr && (q.size() > 0);
    exp_data = 32'h0;
    exp_err  = 1'b0;
    case (addr)
      6'h00: if (!put) exp_data = head_exp();
             else if (q.size() == DEPTH && !pop) exp_err = ERR_EN;
      6'h04: if (!put) exp_data = status_exp();
      6'h08: ;
      default: exp_err = 1'b1;
    endcase
    chk("a_ready_idle", 32'(tl_o.a_ready), 32'h1);
    tick(put && addr == 6'h00, wdata, put && addr == 6'h08 && wdata[0]);
    tl_i.a_valid = 1'b0;
    rdata = tl_o.d_data;
    err   = tl_o.d_error;
    for (int i = 0; i <= hold; i++) begin
      sample_ready = rand_ready ? ($urandom_range(0, 3) == 0) : 1'b0;
      chk("d_valid", 32'(tl_o.d_valid), 32'h1);
      chk("d_opcode", 32'(tl_o.d_opcode), put ? 32'(AccessAck) : 32'(AccessAckData));
      chk("d_source", 32'(tl_o.d_source), 32'(src));
      chk("d_size", 32'(tl_o.d_size), 32'(sz));
      chk("d_data", tl_o.d_data, exp_data);
      chk("d_error", 32'(tl_o.d_error), 32'(exp_err));
      chk("a_ready_busy", 32'(tl_o.a_ready), 32'h0);
      if (i == hold) tl_i.d_ready = 1'b1;
      tick(1'b0, 32'h0, 1'b0);
    end
    tl_i.d_ready = 1'b0;
    chk("d_valid_done", 32'(tl_o.d_valid), 32'h0);
    $display("txn op=%0d addr=0x%02h wdata=0x%08h -> data=0x%08h err=%0d level=%0d",
             op, addr, wdata, rdata, err, q.size());
  endtask

  initial begin
    logic [31:0]   rd;
    bit            er;
    logic [DW-1:0] dut_last;
    logic [5:0]    ad;
    tl_a_op_e      op;
    logic [31:0]   wd;

    vt[0]  = '{Get,         6'h04, 32'h0,    32'h0001_0000, 1'b0};
    vt[1]  = '{PutFullData, 6'h00, 32'h11,   32'h0,         1'b0};
    vt[2]  = '{PutPartialData, 6'h00, 32'h22, 32'h0,        1'b0};
    vt[3]  = '{PutFullData, 6'h00, 32'h33,   32'h0,         1'b0};
    vt[4]  = '{Get,         6'h04, 32'h0,    32'h0000_0003, 1'b0};
    vt[5]  = '{Get,         6'h00, 32'h0,    32'h0000_0011, 1'b0};
    vt[6]  = '{Get,         6'h0C, 32'h0,    32'h0,         1'b1};
    vt[7]  = '{PutFullData, 6'h04, 32'hFFFF, 32'h0,         1'b0};
    vt[8]  = '{Get,         6'h08, 32'h0,    32'h0,         1'b0};
    vt[9]  = '{PutFullData, 6'h3C, 32'h1,    32'h0,         1'b1};
    vt[10] = '{Get,         6'h04, 32'h0,    32'h0000_0003, 1'b0};
    vt[11] = '{PutFullData, 6'h08, 32'h0,    32'h0,         1'b0};
    vt[12] = '{Get,         6'h04, 32'h0,    32'h0000_0003, 1'b0};

    tl_i = '0;
    sample_ready = 1'b0;
    #1 rst_ni = 1'b0;
    #2;
    chk("rst_d_valid", 32'(tl_o.d_valid), 32'h0);
    chk("rst_a_ready", 32'(tl_o.a_ready), 32'h1);
    chk("rst_sample_valid", 32'(sample_valid), 32'h0);
    chk("rst_sample_o", 32'(sample_o), 32'h0);
    #20 rst_ni = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      bus(vt[i].op, vt[i].addr, vt[i].wdata, 1'b0, 0, rd, er);
      chk("vec_data", rd, vt[i].exp_data);
      chk("vec_err", 32'(er), 32'(vt[i].exp_err));
    end
    chk("head_sample_o", 32'(sample_o), 32'h11);
    chk("head_sample_valid", 32'(sample_valid), 32'h1);

    // Overflow: 17 writes into a 16-entry FIFO with the stream stalled.
    bus(PutFullData, 6'h08, 32'h1, 1'b0, 0, rd, er);
    for (int i = 0; i < 17; i++) begin
      bus(PutFullData, 6'h00, 32'(i + 1), 1'b0, 0, rd, er);
      if (i == 16) chk("overflow_ack_err", 32'(er), 32'(ERR_EN));
    end
    bus(Get, 6'h04, 32'h0, 1'b0, 0, rd, er);
    chk("status_overflow_full", rd, 32'h0006_0010);

    // Full FIFO with a concurrent pop accepts the push.
    bus(PutFullData, 6'h08, 32'h1, 1'b0, 0, rd, er);
    for (int i = 0; i < 16; i++) bus(PutFullData, 6'h00, 32'h100 + 32'(i), 1'b0, 0, rd, er);
    bus(PutFullData, 6'h00, 32'h55, 1'b1, 0, rd, er);
    chk("push_pop_full_err", 32'(er), 32'h0);
    bus(Get, 6'h04, 32'h0, 1'b0, 0, rd, er);
    chk("status_full_no_ovf", rd, 32'h0002_0010);
    sample_ready = 1'b1;
    dut_last = '0;
    for (int i = 0; i < 16; i++) begin
      dut_last = sample_o;
      tick(1'b0, 32'h0, 1'b0);
    end
    sample_ready = 1'b0;
    chk("last_popped", 32'(dut_last), 32'h55);
    chk("drained_valid", 32'(sample_valid), 32'h0);

    // Flush with overflow set and level 5.
    bus(PutFullData, 6'h08, 32'h1, 1'b0, 0, rd, er);
    for (int i = 0; i < 17; i++) bus(PutFullData, 6'h00, 32'h200 + 32'(i), 1'b0, 0, rd, er);
    sample_ready = 1'b1;
    repeat (11) tick(1'b0, 32'h0, 1'b0);
    sample_ready = 1'b0;
    bus(Get, 6'h04, 32'h0, 1'b0, 0, rd, er);
    chk("status_lvl5_ovf", rd, 32'h0004_0005);
    bus(PutFullData, 6'h08, 32'h1, 1'b0, 0, rd, er);
    bus(Get, 6'h04, 32'h0, 1'b0, 0, rd, er);
    chk("status_after_flush", rd, 32'h0001_0000);
    bus(Get, 6'h0C, 32'h0, 1'b0, 0, rd, er);
    chk("unmapped_data", rd, 32'h0);
    chk("unmapped_err", 32'(er), 32'h1);

    // Randomized traffic against the queue model.
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 2))
        0: op = Get;
        1: op = PutFullData;
        default: op = PutPartialData;
      endcase
      case ($urandom_range(0, 6))
        0, 1, 2: ad = 6'h00;
        3: ad = 6'h04;
        4: ad = 6'h08;
        5: ad = 6'h0C;
        default: ad = 6'($urandom);
      endcase
      wd = $urandom;
      if (ad == 6'h08 && $urandom_range(0, 7) != 0) wd[0] = 1'b0;
      bus(op, ad, wd, ($urandom_range(0, 3) == 0), $urandom_range(0, 2), rd, er);
    end
    rand_ready = 1'b0;

    // Response held, then reset asserted mid-transaction.
    bus(PutFullData, 6'h00, 32'hAA, 1'b0, 0, rd, er);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = Get;
    tl_i.a_address = 32'h4;
    tl_i.d_ready   = 1'b0;
    wd = status_exp();
    tick(1'b0, 32'h0, 1'b0);
    tl_i.a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_d_valid", 32'(tl_o.d_valid), 32'h1);
      chk("hold_d_data", tl_o.d_data, wd);
      chk("hold_a_ready", 32'(tl_o.a_ready), 32'h0);
      tick(1'b0, 32'h0, 1'b0);
    end
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_d_valid", 32'(tl_o.d_valid), 32'h0);
    chk("async_rst_a_ready", 32'(tl_o.a_ready), 32'h1);
    chk("async_rst_sample_valid", 32'(sample_valid), 32'h0);
    chk("async_rst_sample_o", 32'(sample_o), 32'h0);
    q.delete();
    ovf = 1'b0;
    @(negedge clk) rst_ni = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_no_rsp", 32'(tl_o.d_valid), 32'h0);
      tick(1'b0, 32'h0, 1'b0);
    end
    bus(Get, 6'h04, 32'h0, 1'b0, 0, rd, er);
    chk("post_rst_status", rd, 32'h0001_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/student_tlul_sample_fifo.md
STUDENT_TLUL_SAMPLE_FIFO -- requirements
Module: student_tlul_sample_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of FIFO entries; power of two, range 2..256.
REQ-002 Parameter DW, default 16, sample width in bits; range 1..32.
REQ-003 Port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 Port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 Port tl_i  input  tlul_pkg::tl_h2d_t  TL-UL request from the student_tlul_mux device port.
REQ-006 Port tl_o  output  tlul_pkg::tl_d2h_t  TL-UL response to the student_tlul_mux device port.
REQ-007 Port sample_o  output  DW  FIFO head sample to the FIR core.
REQ-008 Port sample_valid_o  output  1  head sample valid (FIFO not empty).
REQ-009 Port sample_ready_i  input  1  FIR core accepts head sample.

Function
REQ-010 Decode only a_address[5:0]: 0x00 DATA, 0x04 STATUS, 0x08 CTRL; all other offsets are unmapped.
REQ-011 Accept a request when a_valid && a_ready; a_ready = !d_valid (one outstanding response max).
REQ-012 Drive d_valid the cycle after acceptance; hold d_valid and all d_* fields stable until d_ready; d_source and d_size echo the request.
REQ-013 Respond AccessAckData to Get and AccessAck to PutFullData/PutPartialData; d_data = 0 on AccessAck.
REQ-014 DATA write: push wdata[DW-1:0] at acceptance; DATA read: return head zero-extended without popping, 0 when empty.
REQ-015 STATUS read: [8:0] level, [16] empty, [17] full, [18] sticky overflow; STATUS write ignored, acknowledged without error.
REQ-016 CTRL write bit0=1: flush FIFO (level 0) and clear overflow in the cycle after acceptance; CTRL reads 0.
REQ-017 Stream pop when sample_valid_o && sample_ready_i; sample_o = head entry, sample_o = 0 when empty.
REQ-018 Push and pop in the same cycle: both take effect, level unchanged; when full, a push with a concurrent pop is accepted.
REQ-019 Push when full without a concurrent pop: data dropped, overflow bit set.
REQ-020 Flush takes priority over a simultaneous push or pop in the same cycle.
REQ-021 Unmapped offsets: d_error = 1, no state change, d_data = 0.
REQ-022 Read/write pointers wrap modulo DEPTH; level range is 0..DEPTH.

Reset
REQ-023 On rst_ni low, immediately: d_valid = 0, a_ready = 1, level = 0, pointers = 0, overflow = 0, sample_valid_o = 0, sample_o = 0.
REQ-024 Reset asserted mid-transaction discards the pending response; no response is issued after reset release.
REQ-025 FIFO storage array need not be reset.

Configuration
REQ-026 Macro STUDENT_SAMPLE_FIFO_ERR_EN defined: a push dropped per REQ-019 returns d_error = 1 and still sets overflow.
REQ-027 Macro STUDENT_SAMPLE_FIFO_ERR_EN undefined: the dropped push returns d_error = 0; only the overflow bit records it.

Verification
REQ-028 Reset, then read STATUS -> 0x0001_0000 (empty, level 0); sample_valid_o = 0.
REQ-029 Hold sample_ready_i = 0; write DATA 0x11, 0x22, 0x33 -> STATUS level 3, DATA read 0x11, sample_o = 0x11, sample_valid_o = 1.
REQ-030 DEPTH=16: write 17 samples with sample_ready_i = 0 -> STATUS 0x0006_0010; 17th ack d_error = 1 with ERR_EN, 0 without.
REQ-031 Full FIFO, sample_ready_i = 1 during a DATA write 0x55 -> level stays 16; 0x55 is the last sample popped; overflow stays 0.
REQ-032 Write CTRL 0x1 while overflow set and level 5 -> STATUS 0x0001_0000; read offset 0x0C -> d_error = 1, d_data = 0.
REQ-033 Hold d_ready = 0 for 3 cycles after a Get -> d_* stable, a_ready = 0; assert rst_ni low -> d_valid falls immediately.
